// File: rtl/fifo72_xgmii_tx_if.sv
// fifo72_xgmii_tx_if: first-word-fall-through FIFO read port carrying 72-bit {txc,txd} words
interface fifo72_xgmii_tx_if;
    logic [71:0] dout;
    logic        empty;
    logic        rd_en;
    modport master (output dout, output empty, input rd_en);
    modport slave (input dout, input empty, output rd_en);
endinterface

// File: rtl/fifo72_xgmii_tx.sv
// fifo72_xgmii_tx: pops {txc,txd} words from a FWFT FIFO onto XGMII TX with idle fill,
// inter-packet gap, out-of-frame drop and underrun abort.
module fifo72_xgmii_tx #(
    parameter int IPG_WORDS = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    fifo72_xgmii_tx_if.slave     fifo,
    output logic [63:0]          xgmii_txd,
    output logic [7:0]           xgmii_txc,
    output logic                 tx_busy,
    output logic [CNT_WIDTH-1:0] tx_frames,
    output logic [CNT_WIDTH-1:0] tx_underruns,
    output logic [CNT_WIDTH-1:0] tx_drops
);
    localparam logic [71:0] IDLE_W = {8'hFF, 64'h0707070707070707};
    localparam logic [71:0] ERR_W = {8'hFF, 64'hFEFEFEFEFEFEFEFE};
    localparam logic [3:0] GAP_INIT = 4'(IPG_WORDS);
    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN, S_IPG} state_t;
    state_t      state, state_n;
    logic [3:0]  gap, gap_n;
    logic [71:0] word_n;
    logic        is_start, is_term, inc_frame, inc_under, inc_drop;
    assign is_start = fifo.dout[64] && fifo.dout[7:0] == 8'hFD - 8'h02;
    assign tx_busy = state == S_SEND || state == S_DRAIN;
    // a term word may place its FD in any control lane
    always_comb begin
        is_term = 1'b0;
        for (int i = 0; i < 8; i++)
            is_term = is_term | (fifo.dout[64+i] && fifo.dout[8*i +: 8] == 8'hFD);
    end
    always_comb begin
        state_n = state;
        gap_n = gap;
        word_n = IDLE_W;
        fifo.rd_en = 1'b0;
        inc_frame = 1'b0;
        inc_under = 1'b0;
        inc_drop = 1'b0;
        case (state)
            S_IDLE: if (!fifo.empty) begin
                fifo.rd_en = 1'b1;
                word_n = is_start ? fifo.dout : IDLE_W;
                state_n = is_start ? S_SEND : S_IDLE;
                inc_drop = !is_start;
            end
            S_SEND: if (!fifo.empty) begin
                fifo.rd_en = 1'b1;
                word_n = fifo.dout;
                inc_frame = is_term;
                gap_n = is_term ? GAP_INIT : gap;
                state_n = is_term ? S_IPG : S_SEND;
            end else begin
                word_n = ERR_W;
                inc_under = 1'b1;
                state_n = S_DRAIN;
            end
            S_DRAIN: if (!fifo.empty) begin
                fifo.rd_en = 1'b1;
                gap_n = is_term ? GAP_INIT : gap;
                state_n = is_term ? S_IPG : S_DRAIN;
            end
            default: begin
                gap_n = gap - 4'd1;
                state_n = gap == 4'd1 ? S_IDLE : S_IPG;
            end
        endcase
    end
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= S_IPG;
            gap <= GAP_INIT;
            {xgmii_txc, xgmii_txd} <= IDLE_W;
            tx_frames <= '0;
            tx_underruns <= '0;
            tx_drops <= '0;
        end else begin
            state <= state_n;
            gap <= gap_n;
            {xgmii_txc, xgmii_txd} <= word_n;
            if (inc_frame) tx_frames <= tx_frames + ONE;
            if (inc_under) tx_underruns <= tx_underruns + ONE;
            if (inc_drop) tx_drops <= tx_drops + ONE;
        end
    end
endmodule

// File: tb/tb_fifo72_xgmii_tx.sv
// tb_fifo72_xgmii_tx: directed scenarios against a queue-backed FWFT FIFO model
module tb_fifo72_xgmii_tx;
    localparam logic [71:0] IDLE = {8'hFF, 64'h0707070707070707};
    localparam logic [71:0] ERR = {8'hFF, 64'hFEFEFEFEFEFEFEFE};
    localparam logic [71:0] S = {8'h01, 64'hD5555555555555FB};
    localparam logic [71:0] S2 = {8'h01, 64'h0123456789ABCDFB};
    localparam logic [71:0] D = {8'h00, 64'h1122334455667788};
    localparam logic [71:0] D2 = {8'h00, 64'h99AABBCCDDEEFF00};
    localparam logic [71:0] T = {8'hF8, 64'h07070707FDAABBCC};
    localparam logic [71:0] ST = {8'h03, 64'h555555555555FDFB};
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic [63:0] txd;
    logic [7:0] txc;
    logic busy;
    logic [31:0] frames, unders, drops;
    logic [71:0] q[$];
    int passed = 0;
    int total = 0;
    int bad_rd = 0;
    fifo72_xgmii_tx_if ifc();
    fifo72_xgmii_tx #(.IPG_WORDS(2), .CNT_WIDTH(32)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .fifo(ifc),
        .xgmii_txd(txd), .xgmii_txc(txc), .tx_busy(busy),
        .tx_frames(frames), .tx_underruns(unders), .tx_drops(drops)
    );
    always #5 sys_clk = ~sys_clk;
    task drive();
        ifc.empty = q.size() == 0;
        ifc.dout = q.size() != 0 ? q[0] : 72'h0;
    endtask
    task tick();
        bit rd;
        drive();
        #2;
        rd = ifc.rd_en;
        if (rd && ifc.empty) bad_rd++;
        @(posedge sys_clk);
        #1;
        if (rd) void'(q.pop_front());
        drive();
    endtask
    task do_reset();
        sys_rst = 1'b0;
        q.delete();
        tick();
        tick();
        sys_rst = 1'b1;
        tick();
        tick();
    endtask
    task test_reset();
        int pops;
        #1 sys_rst = 1'b0;
        q.push_back(S);
        tick();
        tick();
        total++; if ({txc, txd} !== IDLE) $display("FAIL reset_out: got %h want %h", {txc, txd}, IDLE); else passed++;
        total++; if ({frames, unders, drops} !== 96'h0) $display("FAIL reset_cnt: got %h want 0", {frames, unders, drops}); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (ifc.rd_en !== 1'b0) $display("FAIL reset_rden: got %b want 0", ifc.rd_en); else passed++;
        sys_rst = 1'b1;
        tick();
        tick();
        pops = 1 - q.size();
        total++; if (pops !== 0) $display("FAIL reset_ipg_pop: got %0d pops want 0", pops); else passed++;
        total++; if ({txc, txd} !== IDLE) $display("FAIL reset_ipg_out: got %h want %h", {txc, txd}, IDLE); else passed++;
        tick();
        total++; if ({txc, txd} !== S) $display("FAIL reset_first_pop: got %h want %h", {txc, txd}, S); else passed++;
    endtask
    task test_idle_fill();
        int bad;
        bad = 0;
        do_reset();
        bad_rd = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ({txc, txd} !== IDLE) bad++;
        end
        total++; if (bad !== 0) $display("FAIL idle_fill: got %0d non-idle words want 0", bad); else passed++;
        total++; if (bad_rd !== 0) $display("FAIL idle_rden: got %0d pops on empty want 0", bad_rd); else passed++;
    endtask
    task test_frame();
        do_reset();
        q.push_back(S); q.push_back(D); q.push_back(T);
        tick();
        total++; if ({txc, txd} !== S) $display("FAIL frame_w0: got %h want %h", {txc, txd}, S); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL frame_busy: got %b want 1", busy); else passed++;
        tick();
        total++; if ({txc, txd} !== D) $display("FAIL frame_w1: got %h want %h", {txc, txd}, D); else passed++;
        tick();
        total++; if ({txc, txd} !== T) $display("FAIL frame_w2: got %h want %h", {txc, txd}, T); else passed++;
        total++; if (frames !== 32'd1) $display("FAIL frame_cnt: got %0d want 1", frames); else passed++;
        tick();
        total++; if ({txc, txd} !== IDLE) $display("FAIL frame_ipg0: got %h want %h", {txc, txd}, IDLE); else passed++;
        tick();
        total++; if ({txc, txd} !== IDLE) $display("FAIL frame_ipg1: got %h want %h", {txc, txd}, IDLE); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL frame_idle_busy: got %b want 0", busy); else passed++;
    endtask
    task test_back_to_back();
        do_reset();
        q.push_back(S); q.push_back(D); q.push_back(T);
        q.push_back(S2); q.push_back(D2); q.push_back(T);
        tick(); tick(); tick();
        total++; if ({txc, txd} !== T) $display("FAIL b2b_term: got %h want %h", {txc, txd}, T); else passed++;
        tick(); tick();
        total++; if (q.size() !== 3) $display("FAIL b2b_ipg_hold: got %0d queued want 3", q.size()); else passed++;
        total++; if ({txc, txd} !== IDLE) $display("FAIL b2b_gap: got %h want %h", {txc, txd}, IDLE); else passed++;
        tick();
        total++; if ({txc, txd} !== S2) $display("FAIL b2b_start2: got %h want %h", {txc, txd}, S2); else passed++;
        tick(); tick();
        total++; if ({txc, txd} !== T) $display("FAIL b2b_term2: got %h want %h", {txc, txd}, T); else passed++;
        total++; if (frames !== 32'd2) $display("FAIL b2b_frames: got %0d want 2", frames); else passed++;
    endtask
    task test_start_in_send();
        do_reset();
        q.push_back(S); q.push_back(S2); q.push_back(ST);
        tick(); tick();
        total++; if ({txc, txd} !== S2) $display("FAIL sis_fwd: got %h want %h", {txc, txd}, S2); else passed++;
        tick();
        total++; if ({txc, txd} !== ST) $display("FAIL sis_st: got %h want %h", {txc, txd}, ST); else passed++;
        total++; if (frames !== 32'd1) $display("FAIL sis_frames: got %0d want 1", frames); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL sis_busy: got %b want 0", busy); else passed++;
    endtask
    task test_underrun();
        int bad;
        bad = 0;
        do_reset();
        bad_rd = 0;
        q.push_back(S); q.push_back(D);
        tick(); tick();
        tick();
        total++; if ({txc, txd} !== ERR) $display("FAIL und_err: got %h want %h", {txc, txd}, ERR); else passed++;
        total++; if (unders !== 32'd1) $display("FAIL und_cnt: got %0d want 1", unders); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({txc, txd} !== IDLE) bad++;
        end
        q.push_back(S); q.push_back(D); q.push_back(T);
        tick();
        total++; if (busy !== 1'b1) $display("FAIL und_drain_start: got busy %b want 1", busy); else passed++;
        tick(); tick();
        if ({txc, txd} !== IDLE) bad++;
        total++; if (bad !== 0) $display("FAIL und_drain_idle: got %0d non-idle want 0", bad); else passed++;
        total++; if (q.size() !== 0) $display("FAIL und_drained: got %0d queued want 0", q.size()); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL und_busy: got %b want 0", busy); else passed++;
        total++; if (frames !== 32'd0) $display("FAIL und_frames: got %0d want 0", frames); else passed++;
        total++; if (bad_rd !== 0) $display("FAIL und_rden: got %0d pops on empty want 0", bad_rd); else passed++;
    endtask
    task test_drop();
        do_reset();
        q.push_back(D); q.push_back(S); q.push_back(D2); q.push_back(T);
        tick();
        total++; if ({txc, txd} !== IDLE) $display("FAIL drop_out: got %h want %h", {txc, txd}, IDLE); else passed++;
        total++; if (drops !== 32'd1) $display("FAIL drop_cnt: got %0d want 1", drops); else passed++;
        total++; if (q.size() !== 3) $display("FAIL drop_pop: got %0d queued want 3", q.size()); else passed++;
        tick();
        total++; if ({txc, txd} !== S) $display("FAIL drop_next_start: got %h want %h", {txc, txd}, S); else passed++;
        tick(); tick();
        total++; if (frames !== 32'd1) $display("FAIL drop_frames: got %0d want 1", frames); else passed++;
    endtask
    task test_reset_mid();
        do_reset();
        q.push_back(S); q.push_back(D); q.push_back(T);
        repeat (5) tick();
        q.push_back(S2); q.push_back(D2); q.push_back(D); q.push_back(T);
        tick(); tick();
        total++; if ({txc, txd, busy, frames} !== {D2, 1'b1, 32'd1}) $display("FAIL mid_pre: got %h want %h", {txc, txd, busy, frames}, {D2, 1'b1, 32'd1}); else passed++;
        sys_rst = 1'b0;
        #1;
        total++; if ({txc, txd} !== IDLE) $display("FAIL mid_out: got %h want %h", {txc, txd}, IDLE); else passed++;
        total++; if ({frames, busy, ifc.rd_en} !== 34'd0) $display("FAIL mid_state: got %h want 0", {frames, busy, ifc.rd_en}); else passed++;
        #2 sys_rst = 1'b1;
        tick(); tick();
        total++; if (q.size() !== 2) $display("FAIL mid_ipg_hold: got %0d queued want 2", q.size()); else passed++;
        tick();
        total++; if (drops !== 32'd1 || q.size() !== 1) $display("FAIL mid_drop: got drops %0d queued %0d want 1 and 1", drops, q.size()); else passed++;
    endtask
    initial begin
        drive();
        test_reset();
        test_idle_fill();
        test_frame();
        test_back_to_back();
        test_start_in_send();
        test_underrun();
        test_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
